// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package debounce_pkg;

  // Per-channel FSM encoding: STABLE idles, PENDING counts agreeing samples.
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Counter width able to hold the largest of the three cycle counts.
  function automatic int cnt_w(input int stable_cycles,
                               input int repeat_delay,
                               input int repeat_period);
    int m;
    m = stable_cycles;
    if (repeat_delay > m)  m = repeat_delay;
    if (repeat_period > m) m = repeat_period;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: synchroniser, glitch-rejecting stability counter, edge strobes.
// Latency: SYNC_STAGES + STABLE_CYCLES cycles from a clean btn_in edge to btn_out.
// Backpressure: none; free-running, strobes are single-cycle and never held.
//
// Ports:
//   clk, reset    clock and asynchronous active-low reset
//   btn_in        raw asynchronous input
//   btn_out       registered debounced level
//   rise_pulse    1-cycle strobe on the edge btn_out goes 0->1
//   fall_pulse    1-cycle strobe on the edge btn_out goes 1->0
//   repeat_pulse  hold-to-repeat strobe (MULTI_DEBOUNCE_REPEAT_EN), else tied 0
//   busy          high while a candidate change is being timed
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 500000,
  parameter int   SYNC_STAGES   = 2,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   REPEAT_DELAY  = 50000000,
  parameter int   REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic repeat_pulse,
  output logic busy
);

  localparam int CNT_W = cnt_w(STABLE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign busy = (state == ST_PENDING);

  // cnt tracks how many consecutive cycles s has disagreed with btn_out;
  // the change is accepted on the STABLE_CYCLES-th such cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_STABLE;
      cnt        <= '0;
      btn_out    <= RESET_LEVEL;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      case (state)
        ST_STABLE: begin
          cnt <= '0;
          if (s != btn_out) begin
            state <= ST_PENDING;
            cnt   <= CNT_W'(1);
          end
        end
        ST_PENDING: begin
          if (s == btn_out) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            btn_out    <= s;
            rise_pulse <= s;
            fall_pulse <= ~s;
            state      <= ST_STABLE;
            cnt        <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef MULTI_DEBOUNCE_REPEAT_EN
  logic             accept_fall;
  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_first;

  // Fall accepted this edge: suppress any repeat that would coincide with it.
  assign accept_fall = (state == ST_PENDING) && (s != btn_out) &&
                       (cnt == CNT_LAST) && btn_out;

  // Counter restarts on the rise edge (btn_out still 0 there), so the first
  // strobe lands REPEAT_DELAY edges after rise_pulse, then every REPEAT_PERIOD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rpt_cnt      <= '0;
      rpt_first    <= 1'b1;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (!btn_out || accept_fall) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else if (rpt_cnt == (rpt_first ? CNT_W'(REPEAT_DELAY - 1)
                                         : CNT_W'(REPEAT_PERIOD - 1))) begin
        repeat_pulse <= 1'b1;
        rpt_cnt      <= '0;
        rpt_first    <= 1'b0;
      end else begin
        rpt_cnt <= rpt_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/multi_debounce.sv
// N-channel debouncer for raw buttons/switches; channels are fully independent.
// Latency: SYNC_STAGES + STABLE_CYCLES cycles from a clean input edge to btn_out.
// Backpressure: none; outputs are free-running levels and single-cycle strobes.
//
// Ports (all CHANNELS wide except clk/reset):
//   clk, reset    100 MHz clock, asynchronous active-low reset
//   btn_in        raw asynchronous inputs
//   btn_out       debounced levels
//   rise_pulse    0->1 strobes, fall_pulse 1->0 strobes
//   repeat_pulse  hold-to-repeat strobes (only with MULTI_DEBOUNCE_REPEAT_EN)
//   busy          channel is timing a candidate change
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int   CHANNELS      = 4,
  parameter int   STABLE_CYCLES = 500000,
  parameter int   SYNC_STAGES   = 2,
  parameter logic RESET_LEVEL   = 1'b0,
  parameter int   REPEAT_DELAY  = 50000000,
  parameter int   REPEAT_PERIOD = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic [CHANNELS-1:0] busy
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .RESET_LEVEL  (RESET_LEVEL),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .btn_in      (btn_in[i]),
      .btn_out     (btn_out[i]),
      .rise_pulse  (rise_pulse[i]),
      .fall_pulse  (fall_pulse[i]),
      .repeat_pulse(repeat_pulse[i]),
      .busy        (busy[i])
    );
  end

endmodule
